// File: rtl/pe_dma_mem_responder.sv
// Memory-side responder for the PE DMA request interface: drives a fixed-latency
// single-port SRAM and returns in-order responses through a credit-limited FIFO.
module pe_dma_mem_responder #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 64,
    parameter int TAG_WIDTH      = 4,
    parameter int MEM_DEPTH      = 4096,
    parameter int MEM_LATENCY    = 2,
    parameter int RSP_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  dma__mem__req_valid,
    input  logic                  dma__mem__req_write,
    input  logic [ADDR_WIDTH-1:0] dma__mem__req_addr,
    input  logic [DATA_WIDTH-1:0] dma__mem__req_wdata,
    input  logic [TAG_WIDTH-1:0]  dma__mem__req_tag,
    output logic                  mem__dma__req_ready,
    output logic                  mem__dma__rsp_valid,
    output logic                  mem__dma__rsp_write,
    output logic                  mem__dma__rsp_err,
    output logic [TAG_WIDTH-1:0]  mem__dma__rsp_tag,
    output logic [DATA_WIDTH-1:0] mem__dma__rsp_data,
    input  logic                  dma__mem__rsp_ready,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam int CW  = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int PW  = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int AW1 = ADDR_WIDTH + 1;

    typedef struct packed {
        logic                 vld;
        logic                 write;
        logic                 err;
        logic [TAG_WIDTH-1:0] tag;
    } side_t;

    typedef struct packed {
        logic                  write;
        logic                  err;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    logic                              req_ready_q, req_ready_d;
    logic [CW-1:0]                     count_q, count_d;
    side_t [MEM_LATENCY-1:0]           pipe_q, pipe_d;
    rsp_t  [RSP_FIFO_DEPTH-1:0]        fifo_q, fifo_d;
    logic [PW-1:0]                     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                     fcnt_q, fcnt_d;

    logic  accept, in_range, issue, push, pop, rsp_vld;
    side_t tail;
    rsp_t  push_ent, head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Request side: accept only against registered credit state.
    always_comb begin
        accept     = dma__mem__req_valid & req_ready_q;
        in_range   = {1'b0, dma__mem__req_addr} < AW1'(MEM_DEPTH);
        issue      = accept & in_range;
        sram_en    = issue;
        sram_we    = issue & dma__mem__req_write;
        sram_addr  = issue ? dma__mem__req_addr : '0;
        sram_wdata = (issue & dma__mem__req_write) ? dma__mem__req_wdata : '0;
    end

    // Sideband travels alongside the SRAM read so it lines up with sram_rdata.
    always_comb begin
        pipe_d           = pipe_q;
        pipe_d[0].vld    = accept;
        pipe_d[0].write  = accept & dma__mem__req_write;
        pipe_d[0].err    = accept & ~in_range;
        pipe_d[0].tag    = accept ? dma__mem__req_tag : '0;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        tail           = pipe_q[MEM_LATENCY-1];
        push           = tail.vld;
        push_ent.write = tail.write;
        push_ent.err   = tail.err;
        push_ent.tag   = tail.tag;
        push_ent.data  = (tail.vld & ~tail.write & ~tail.err) ? sram_rdata : '0;
    end

    // Response FIFO; the credit counter covers both pipeline and FIFO, so push never finds it full.
    always_comb begin
        rsp_vld  = (fcnt_q != '0);
        head     = fifo_q[rd_ptr_q];
        pop      = rsp_vld & dma__mem__rsp_ready;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_ent;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        fcnt_d      = fcnt_q + CW'(push) - CW'(pop);
        count_d     = count_q + CW'(accept) - CW'(pop);
        req_ready_d = (count_d < CW'(RSP_FIFO_DEPTH));
    end

    always_comb begin
        mem__dma__req_ready = req_ready_q;
        mem__dma__rsp_valid = rsp_vld;
        mem__dma__rsp_write = rsp_vld & head.write;
        mem__dma__rsp_err   = rsp_vld & head.err;
        mem__dma__rsp_tag   = rsp_vld ? head.tag  : '0;
        mem__dma__rsp_data  = rsp_vld ? head.data : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready_q <= 1'b0;
            count_q     <= '0;
            pipe_q      <= '0;
            fifo_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
        end else begin
            req_ready_q <= req_ready_d;
            count_q     <= count_d;
            pipe_q      <= pipe_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcnt_q      <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_pe_dma_mem_responder.sv
// Directed bench for pe_dma_mem_responder with a 2-cycle-latency SRAM model.
module tb_pe_dma_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_write;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  req_tag;
    logic        req_ready;
    logic        rsp_valid, rsp_write, rsp_err;
    logic [3:0]  rsp_tag;
    logic [63:0] rsp_data;
    logic        rsp_ready;
    logic        sram_en, sram_we;
    logic [15:0] sram_addr;
    logic [63:0] sram_wdata, sram_rdata;
    logic [6:0]  hdr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pe_dma_mem_responder dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .dma__mem__req_valid (req_valid),
        .dma__mem__req_write (req_write),
        .dma__mem__req_addr  (req_addr),
        .dma__mem__req_wdata (req_wdata),
        .dma__mem__req_tag   (req_tag),
        .mem__dma__req_ready (req_ready),
        .mem__dma__rsp_valid (rsp_valid),
        .mem__dma__rsp_write (rsp_write),
        .mem__dma__rsp_err   (rsp_err),
        .mem__dma__rsp_tag   (rsp_tag),
        .mem__dma__rsp_data  (rsp_data),
        .dma__mem__rsp_ready (rsp_ready),
        .sram_en             (sram_en),
        .sram_we             (sram_we),
        .sram_addr           (sram_addr),
        .sram_wdata          (sram_wdata),
        .sram_rdata          (sram_rdata)
    );

    assign hdr = {rsp_valid, rsp_write, rsp_err, rsp_tag};

    // SRAM model: write-first, read data appears two cycles after the enable.
    logic [63:0] mem [0:65535];
    logic [63:0] rd_s0, rd_s1;
    always @(posedge clk) begin
        if (sram_en && sram_we)  mem[sram_addr] <= sram_wdata;
        if (sram_en && !sram_we) rd_s0 <= mem[sram_addr];
        rd_s1 <= rd_s0;
    end
    assign sram_rdata = rd_s1;

    // Outstanding-request tracker: FIFO overflow would show up as more than 4 in flight.
    int   outst;
    logic ovf_seen = 1'b0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) outst <= 0;
        else outst <= outst + ((req_valid && req_ready) ? 1 : 0) - ((rsp_valid && rsp_ready) ? 1 : 0);
    end
    always @(negedge clk) begin
        if (outst > 4 || outst < 0) ovf_seen <= 1'b1;
    end

    function automatic logic [63:0] pat(input int i);
        return 64'hA5A5_0000_0000_0000 + 64'(i);
    endfunction

    task automatic drv(input logic v, input logic w, input logic [15:0] a,
                       input logic [63:0] d, input logic [3:0] t);
        req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_tag = t;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rsp_ready = 1'b1;
        drv(1'b1, 1'b0, 16'h0001, 64'h0, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset req_ready: got %b exp 0", req_ready); end
        n_tests++; if ({hdr, rsp_data} !== 71'h0) begin n_fail++; $display("FAIL reset rsp: got %h/%h exp 0", hdr, rsp_data); end
        n_tests++; if ({sram_en, sram_we, sram_addr, sram_wdata} !== 82'h0) begin n_fail++; $display("FAIL reset sram: got en=%b addr=%h exp 0", sram_en, sram_addr); end
        drv(1'b0, 1'b0, 16'h0, 64'h0, 4'h0);
        reset_n = 1'b1;
        cyc(); @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset req_ready: got %b exp 1", req_ready); end
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        cyc(); drv(1'b1, 1'b1, 16'h0010, 64'hDEADBEEF_CAFEF00D, 4'd3); @(negedge clk);
        n_tests++; if ({sram_en, sram_we, sram_addr} !== {2'b11, 16'h0010}) begin n_fail++; $display("FAIL wr sram: got en/we=%b%b addr=%h exp 11/0010", sram_en, sram_we, sram_addr); end
        n_tests++; if (sram_wdata !== 64'hDEADBEEF_CAFEF00D) begin n_fail++; $display("FAIL wr wdata: got %h exp deadbeefcafef00d", sram_wdata); end
        cyc(); drv(1'b1, 1'b0, 16'h0010, 64'h0, 4'd5); @(negedge clk);
        n_tests++; if ({sram_en, sram_we} !== 2'b10) begin n_fail++; $display("FAIL rd sram: got en/we=%b%b exp 10", sram_en, sram_we); end
        cyc(); drv(1'b0, 1'b0, 16'h0, 64'h0, 4'h0); @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr early rsp: got %b exp 0", rsp_valid); end
        cyc(); @(negedge clk);
        n_tests++; if (hdr !== {3'b110, 4'd3}) begin n_fail++; $display("FAIL wr ack hdr: got %h exp %h", hdr, {3'b110, 4'd3}); end
        n_tests++; if (rsp_data !== 64'h0) begin n_fail++; $display("FAIL wr ack data: got %h exp 0", rsp_data); end
        cyc(); @(negedge clk);
        n_tests++; if (hdr !== {3'b100, 4'd5}) begin n_fail++; $display("FAIL rd rsp hdr: got %h exp %h", hdr, {3'b100, 4'd5}); end
        n_tests++; if (rsp_data !== 64'hDEADBEEF_CAFEF00D) begin n_fail++; $display("FAIL rd rsp data: got %h exp deadbeefcafef00d", rsp_data); end
        cyc(); @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd drained: got %b exp 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        // back-to-back writes of a known pattern, acks checked in order
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (c < 8) drv(1'b1, 1'b1, 16'(c), pat(c), 4'(c));
            else       drv(1'b0, 1'b0, 16'h0, 64'h0, 4'h0);
            @(negedge clk);
            if (c < 8) begin
                n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b wr ready c=%0d: got %b exp 1", c, req_ready); end
            end
            if (c >= 3 && c < 11) begin
                n_tests++; if (hdr !== {3'b110, 4'(c - 3)}) begin n_fail++; $display("FAIL b2b wr ack c=%0d: got %h exp %h", c, hdr, {3'b110, 4'(c - 3)}); end
            end
        end
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (c < 8) drv(1'b1, 1'b0, 16'(c), 64'h0, 4'(c));
            else       drv(1'b0, 1'b0, 16'h0, 64'h0, 4'h0);
            @(negedge clk);
            if (c < 8) begin
                n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b rd ready c=%0d: got %b exp 1", c, req_ready); end
            end
            if (c >= 3 && c < 11) begin
                n_tests++; if (hdr !== {3'b100, 4'(c - 3)}) begin n_fail++; $display("FAIL b2b rd hdr c=%0d: got %h exp %h", c, hdr, {3'b100, 4'(c - 3)}); end
                n_tests++; if (rsp_data !== pat(c - 3)) begin n_fail++; $display("FAIL b2b rd data c=%0d: got %h exp %h", c, rsp_data, pat(c - 3)); end
            end
            if (c < 3 || c == 11) begin
                n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b rd idle c=%0d: got %b exp 0", c, rsp_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cyc(); drv(1'b1, 1'b0, 16'(16'h0020 + c), 64'h0, 4'(c)); @(negedge clk);
            if (req_valid && req_ready) acc++;
        end
        cyc(); drv(1'b0, 1'b0, 16'h0, 64'h0, 4'h0); @(negedge clk);
        n_tests++; if (acc !== 4) begin n_fail++; $display("FAIL bp accepted: got %0d exp 4", acc); end
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp ready full: got %b exp 0", req_ready); end
        n_tests++; if (hdr !== {3'b100, 4'd0}) begin n_fail++; $display("FAIL bp head: got %h exp %h", hdr, {3'b100, 4'd0}); end
        cyc(); rsp_ready = 1'b1; @(negedge clk);
        n_tests++; if (hdr !== {3'b100, 4'd0}) begin n_fail++; $display("FAIL bp pop0: got %h exp %h", hdr, {3'b100, 4'd0}); end
        cyc(); rsp_ready = 1'b0; @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp ready reopen: got %b exp 1", req_ready); end
        n_tests++; if (hdr !== {3'b100, 4'd1}) begin n_fail++; $display("FAIL bp head1: got %h exp %h", hdr, {3'b100, 4'd1}); end
        cyc(); @(negedge clk);
        n_tests++; if (hdr !== {3'b100, 4'd1}) begin n_fail++; $display("FAIL bp hold: got %h exp %h", hdr, {3'b100, 4'd1}); end
        for (int k = 1; k < 4; k++) begin
            cyc(); rsp_ready = 1'b1; @(negedge clk);
            n_tests++; if (hdr !== {3'b100, 4'(k)}) begin n_fail++; $display("FAIL bp drain k=%0d: got %h exp %h", k, hdr, {3'b100, 4'(k)}); end
        end
        cyc(); @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp empty: got %b exp 0", rsp_valid); end
    endtask

    task automatic test_out_of_range();
        rsp_ready = 1'b1;
        cyc(); drv(1'b1, 1'b0, 16'h1000, 64'h0, 4'd9); @(negedge clk);
        n_tests++; if (sram_en !== 1'b0) begin n_fail++; $display("FAIL oor sram_en: got %b exp 0", sram_en); end
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL oor ready: got %b exp 1", req_ready); end
        cyc(); drv(1'b0, 1'b0, 16'h0, 64'h0, 4'h0); @(negedge clk);
        cyc(); @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL oor early: got %b exp 0", rsp_valid); end
        cyc(); @(negedge clk);
        n_tests++; if (hdr !== {3'b101, 4'd9}) begin n_fail++; $display("FAIL oor hdr: got %h exp %h", hdr, {3'b101, 4'd9}); end
        n_tests++; if (rsp_data !== 64'h0) begin n_fail++; $display("FAIL oor data: got %h exp 0", rsp_data); end
        cyc(); @(negedge clk);
    endtask

    task automatic test_simultaneous();
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc(); drv(1'b1, 1'b0, 16'(c), 64'h0, 4'(10 + c)); @(negedge clk);
        end
        cyc(); drv(1'b0, 1'b0, 16'h0, 64'h0, 4'h0); @(negedge clk);
        cyc(); @(negedge clk);
        cyc(); drv(1'b1, 1'b0, 16'd3, 64'h0, 4'd13); rsp_ready = 1'b1; @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL sim ready at 3: got %b exp 1", req_ready); end
        n_tests++; if (hdr !== {3'b100, 4'd10}) begin n_fail++; $display("FAIL sim head: got %h exp %h", hdr, {3'b100, 4'd10}); end
        n_tests++; if (rsp_data !== pat(0)) begin n_fail++; $display("FAIL sim head data: got %h exp %h", rsp_data, pat(0)); end
        cyc(); drv(1'b1, 1'b0, 16'd4, 64'h0, 4'd14); rsp_ready = 1'b0; @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL sim ready kept: got %b exp 1", req_ready); end
        cyc(); drv(1'b0, 1'b0, 16'h0, 64'h0, 4'h0); @(negedge clk);
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sim ready full: got %b exp 0", req_ready); end
        for (int k = 1; k < 5; k++) begin
            cyc(); rsp_ready = 1'b1; @(negedge clk);
            n_tests++; if (hdr !== {3'b100, 4'(10 + k)}) begin n_fail++; $display("FAIL sim order k=%0d: got %h exp %h", k, hdr, {3'b100, 4'(10 + k)}); end
            n_tests++; if (rsp_data !== pat(k)) begin n_fail++; $display("FAIL sim data k=%0d: got %h exp %h", k, rsp_data, pat(k)); end
        end
        cyc(); @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sim empty: got %b exp 0", rsp_valid); end
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc(); drv(1'b1, 1'b0, 16'(5 + c), 64'h0, 4'(1 + c)); @(negedge clk);
        end
        cyc(); drv(1'b1, 1'b0, 16'd5, 64'h0, 4'd1);
        reset_n = 1'b0;
        #1;
        n_tests++; if ({req_ready, hdr, rsp_data} !== 72'h0) begin n_fail++; $display("FAIL midrst rsp: got rdy=%b hdr=%h data=%h exp 0", req_ready, hdr, rsp_data); end
        n_tests++; if ({sram_en, sram_we, sram_addr, sram_wdata} !== 82'h0) begin n_fail++; $display("FAIL midrst sram: got en=%b addr=%h exp 0", sram_en, sram_addr); end
        drv(1'b0, 1'b0, 16'h0, 64'h0, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc(); @(negedge clk);
            n_tests++; if ({req_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL midrst stale c=%0d: got rdy/vld=%b%b exp 10", c, req_ready, rsp_valid); end
        end
        cyc(); drv(1'b1, 1'b0, 16'd2, 64'h0, 4'd7); @(negedge clk);
        cyc(); drv(1'b0, 1'b0, 16'h0, 64'h0, 4'h0); @(negedge clk);
        cyc(); @(negedge clk);
        cyc(); @(negedge clk);
        n_tests++; if (hdr !== {3'b100, 4'd7}) begin n_fail++; $display("FAIL midrst new hdr: got %h exp %h", hdr, {3'b100, 4'd7}); end
        n_tests++; if (rsp_data !== pat(2)) begin n_fail++; $display("FAIL midrst new data: got %h exp %h", rsp_data, pat(2)); end
        cyc(); @(negedge clk);
    endtask

    task automatic test_no_overflow();
        n_tests++; if (ovf_seen !== 1'b0) begin n_fail++; $display("FAIL overflow: got outstanding>4 flag %b exp 0", ovf_seen); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_out_of_range();
        test_simultaneous();
        test_reset_midflight();
        test_no_overflow();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
